// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package hazard_pkg;

   localparam int HZ_REG_AW = 5;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1,
      FLUSH   = 2'd2
   } hz_state_e;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   // True when a written, non-x0 destination matches the source register.
   function automatic logic reg_match(input logic [HZ_REG_AW-1:0] addr,
                                      input logic [HZ_REG_AW-1:0] rd,
                                      input logic                 wren);
      return wren && (rd != '0) && (rd == addr);
   endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of pipeline status inputs and control outputs of the hazard controller.
// Latency: n/a (wiring only).
// Backpressure: the *_stall_en advance enables are the pipeline's stall mechanism.
interface hazard_control_unit_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic [REG_AW-1:0] ID_rs1_addr;
   logic [REG_AW-1:0] ID_rs2_addr;
   logic              ID_rs1_used;
   logic              ID_rs2_used;
   logic [REG_AW-1:0] EX_rs1_addr;
   logic [REG_AW-1:0] EX_rs2_addr;
   logic [REG_AW-1:0] EX_rd_addr;
   logic              EX_rd_wren;
   logic              EX_ld_en;
   logic              EX_md_en;
   logic [REG_AW-1:0] MEM_rd_addr;
   logic              MEM_rd_wren;
   logic [REG_AW-1:0] WB_rd_addr;
   logic              WB_rd_wren;
   logic              MEM_pc_br;
   logic              md_done_i;

   logic [1:0]        forwardA_en;
   logic [1:0]        forwardB_en;
   logic              IF_stall_en;
   logic              ID_stall_en;
   logic              EX_stall_en;
   logic              IF_rst_n;
   logic              ID_rst_n;
   logic              EX_rst_n;
   logic              md_start_o;
   logic              md_timeout_o;
   logic [CNT_W-1:0]  stall_cycles_o;
   logic [CNT_W-1:0]  flush_count_o;

   // Pipeline side: reports stage status, consumes control.
   modport master (
      output ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
             EX_rs1_addr, EX_rs2_addr, EX_rd_addr, EX_rd_wren, EX_ld_en, EX_md_en,
             MEM_rd_addr, MEM_rd_wren, WB_rd_addr, WB_rd_wren, MEM_pc_br, md_done_i,
      input  forwardA_en, forwardB_en, IF_stall_en, ID_stall_en, EX_stall_en,
             IF_rst_n, ID_rst_n, EX_rst_n, md_start_o, md_timeout_o,
             stall_cycles_o, flush_count_o
   );

   // Controller side.
   modport slave (
      input  ID_rs1_addr, ID_rs2_addr, ID_rs1_used, ID_rs2_used,
             EX_rs1_addr, EX_rs2_addr, EX_rd_addr, EX_rd_wren, EX_ld_en, EX_md_en,
             MEM_rd_addr, MEM_rd_wren, WB_rd_addr, WB_rd_wren, MEM_pc_br, md_done_i,
      output forwardA_en, forwardB_en, IF_stall_en, ID_stall_en, EX_stall_en,
             IF_rst_n, ID_rst_n, EX_rst_n, md_start_o, md_timeout_o,
             stall_cycles_o, flush_count_o
   );
endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping.
// Latency: count visible the cycle after inc_i.
// Backpressure: none; one event per cycle at most.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] cnt_o
);

   // Count up on inc_i, stick at all-ones, synchronous clear wins.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: forwarding, load-use bubbles, branch flushes, MUL/DIV hold.
// Latency: all controls combinational from current inputs and state; no added delay.
// Backpressure: stalls IF/ID/EX via *_stall_en while a MUL/DIV is in flight or on load-use.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = HZ_REG_AW,
   parameter int CNT_W      = 16,
   parameter int MD_TIMEOUT = 64
) (
   input logic                clk_i,
   input logic                rst_i,
   hazard_control_unit_if.slave hz
);

   localparam int WC_W = $clog2(MD_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MD_TIMEOUT - 1);

   hz_state_e       state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q;
   logic            md_fired_q;
   logic            md_timeout_q;

   logic            lu;
   logic            release_md;
   logic            timeout_hit;
   logic            flush_inc;
   logic            if_en, id_en, ex_en;
   logic            if_rn, id_rn, ex_rn;
   logic            md_start;
   logic [1:0]      fwd_a, fwd_b;

   // Operand forwarding: MEM beats WB, x0 never forwarded.
   always_comb begin
      fwd_a = FWD_NONE;
      fwd_b = FWD_NONE;
      if (reg_match(hz.EX_rs1_addr, hz.MEM_rd_addr, hz.MEM_rd_wren))     fwd_a = FWD_MEM;
      else if (reg_match(hz.EX_rs1_addr, hz.WB_rd_addr, hz.WB_rd_wren))  fwd_a = FWD_WB;
      if (reg_match(hz.EX_rs2_addr, hz.MEM_rd_addr, hz.MEM_rd_wren))     fwd_b = FWD_MEM;
      else if (reg_match(hz.EX_rs2_addr, hz.WB_rd_addr, hz.WB_rd_wren))  fwd_b = FWD_WB;
   end

   assign lu = hz.EX_ld_en &&
               (reg_match(hz.ID_rs1_addr, hz.EX_rd_addr, hz.EX_rd_wren && hz.ID_rs1_used) ||
                reg_match(hz.ID_rs2_addr, hz.EX_rd_addr, hz.EX_rd_wren && hz.ID_rs2_used));

   // Stage controls and next state; flush > mul/div > load-use, all quiet in reset.
   always_comb begin
      state_d     = state_q;
      if_en       = 1'b1;
      id_en       = 1'b1;
      ex_en       = 1'b1;
      if_rn       = 1'b1;
      id_rn       = 1'b1;
      ex_rn       = 1'b1;
      md_start    = 1'b0;
      release_md  = 1'b0;
      timeout_hit = 1'b0;
      flush_inc   = 1'b0;
      if (!rst_i) begin
         case (state_q)
            RUN: begin
               if (hz.MEM_pc_br) begin
                  if_rn     = 1'b0;
                  id_rn     = 1'b0;
                  ex_rn     = 1'b0;
                  flush_inc = 1'b1;
                  state_d   = FLUSH;
               end else if (hz.EX_md_en && !md_fired_q) begin
                  md_start = 1'b1;
                  if_en    = 1'b0;
                  id_en    = 1'b0;
                  ex_en    = 1'b0;
                  state_d  = MD_WAIT;
               end else if (lu) begin
                  if_en = 1'b0;
                  id_en = 1'b0;
                  id_rn = 1'b0;
               end
            end
            MD_WAIT: begin
               // A redirect cannot reach MEM here, so MEM_pc_br is ignored.
               if (hz.md_done_i || (wait_cnt_q == WAIT_LAST)) begin
                  release_md  = 1'b1;
                  timeout_hit = !hz.md_done_i;
                  state_d     = RUN;
               end else begin
                  if_en = 1'b0;
                  id_en = 1'b0;
                  ex_en = 1'b0;
               end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
         endcase
      end
   end

   // State, wait counter, restart suppression and sticky timeout.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= RUN;
         wait_cnt_q   <= '0;
         md_fired_q   <= 1'b0;
         md_timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == MD_WAIT) && !release_md) wait_cnt_q <= wait_cnt_q + 1'b1;
         else                                     wait_cnt_q <= '0;
         if (release_md)  md_fired_q <= 1'b1;
         else if (ex_en)  md_fired_q <= 1'b0;
         if (timeout_hit) md_timeout_q <= 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (!if_en),
      .clr_i (1'b0),
      .cnt_o (hz.stall_cycles_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc_i (flush_inc),
      .clr_i (1'b0),
      .cnt_o (hz.flush_count_o)
   );

   assign hz.forwardA_en  = fwd_a;
   assign hz.forwardB_en  = fwd_b;
   assign hz.IF_stall_en  = if_en;
   assign hz.ID_stall_en  = id_en;
   assign hz.EX_stall_en  = ex_en;
   assign hz.IF_rst_n     = if_rn;
   assign hz.ID_rst_n     = id_rn;
   assign hz.EX_rst_n     = ex_rn;
   assign hz.md_start_o   = md_start;
   assign hz.md_timeout_o = md_timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for the hazard controller with a short MUL/DIV timeout.
// Latency: outputs sampled 3 time units after the clock edge that applied inputs.
// Backpressure: stage enables checked against hand-derived cycle counts.
module tb_hazard_control_unit;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   checks = 0;
   int   errors = 0;

   hazard_control_unit_if #(.REG_AW(5), .CNT_W(16)) hz_if ();

   hazard_control_unit #(.REG_AW(5), .CNT_W(16), .MD_TIMEOUT(8)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .hz    (hz_if)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_en(input string tag, input logic e);
      chk({tag, "_if_en"}, 32'(hz_if.IF_stall_en), 32'(e));
      chk({tag, "_id_en"}, 32'(hz_if.ID_stall_en), 32'(e));
      chk({tag, "_ex_en"}, 32'(hz_if.EX_stall_en), 32'(e));
   endtask

   initial begin
      hz_if.ID_rs1_addr = '0; hz_if.ID_rs2_addr = '0;
      hz_if.ID_rs1_used = 0;  hz_if.ID_rs2_used = 0;
      hz_if.EX_rs1_addr = '0; hz_if.EX_rs2_addr = '0;
      hz_if.EX_rd_addr  = '0; hz_if.EX_rd_wren  = 0;
      hz_if.EX_ld_en    = 0;  hz_if.EX_md_en    = 0;
      hz_if.MEM_rd_addr = '0; hz_if.MEM_rd_wren = 0;
      hz_if.WB_rd_addr  = '0; hz_if.WB_rd_wren  = 0;
      hz_if.MEM_pc_br   = 0;  hz_if.md_done_i   = 0;

      // Reset state
      #3;
      chk_en("rst", 1'b1);
      chk("rst_if_rn", 32'(hz_if.IF_rst_n), 32'd1);
      chk("rst_ex_rn", 32'(hz_if.EX_rst_n), 32'd1);
      chk("rst_start", 32'(hz_if.md_start_o), 32'd0);
      chk("rst_stall", 32'(hz_if.stall_cycles_o), 32'd0);
      chk("rst_flush", 32'(hz_if.flush_count_o), 32'd0);
      chk("rst_tmo", 32'(hz_if.md_timeout_o), 32'd0);
      tick(); tick();
      rst_i = 1'b0;

      // Forwarding
      tick();
      hz_if.EX_rs1_addr = 5; hz_if.MEM_rd_addr = 5; hz_if.MEM_rd_wren = 1;
      hz_if.WB_rd_addr = 5;  hz_if.WB_rd_wren = 1;
      #2;
      chk("fwdA_mem", 32'(hz_if.forwardA_en), 32'd2);
      chk("fwdB_none", 32'(hz_if.forwardB_en), 32'd0);
      hz_if.MEM_rd_wren = 0;
      #1;
      chk("fwdA_wb", 32'(hz_if.forwardA_en), 32'd1);
      hz_if.EX_rs1_addr = 0; hz_if.MEM_rd_addr = 0; hz_if.MEM_rd_wren = 1;
      hz_if.WB_rd_addr = 0;
      #1;
      chk("fwdA_x0", 32'(hz_if.forwardA_en), 32'd0);
      hz_if.EX_rs2_addr = 9; hz_if.WB_rd_addr = 9; hz_if.MEM_rd_addr = 4;
      #1;
      chk("fwdB_wb", 32'(hz_if.forwardB_en), 32'd1);
      hz_if.MEM_rd_addr = 9;
      #1;
      chk("fwdB_mem", 32'(hz_if.forwardB_en), 32'd2);
      hz_if.EX_rs2_addr = 0; hz_if.MEM_rd_wren = 0; hz_if.WB_rd_wren = 0;

      // Load-use bubble
      tick();
      hz_if.EX_ld_en = 1; hz_if.EX_rd_wren = 1; hz_if.EX_rd_addr = 7;
      hz_if.ID_rs2_addr = 7; hz_if.ID_rs2_used = 1;
      #2;
      chk("lu_if_en", 32'(hz_if.IF_stall_en), 32'd0);
      chk("lu_id_en", 32'(hz_if.ID_stall_en), 32'd0);
      chk("lu_ex_en", 32'(hz_if.EX_stall_en), 32'd1);
      chk("lu_id_rn", 32'(hz_if.ID_rst_n), 32'd0);
      chk("lu_if_rn", 32'(hz_if.IF_rst_n), 32'd1);
      tick();
      hz_if.ID_rs2_used = 0;
      #2;
      chk("lu_unused_en", 32'(hz_if.IF_stall_en), 32'd1);
      chk("lu_stall_cnt", 32'(hz_if.stall_cycles_o), 32'd1);
      tick();
      chk("lu_stall_cnt2", 32'(hz_if.stall_cycles_o), 32'd1);

      // Branch held two cycles: only the first flushes
      hz_if.EX_ld_en = 0;
      hz_if.MEM_pc_br = 1;
      #2;
      chk("br_if_rn", 32'(hz_if.IF_rst_n), 32'd0);
      chk("br_id_rn", 32'(hz_if.ID_rst_n), 32'd0);
      chk("br_ex_rn", 32'(hz_if.EX_rst_n), 32'd0);
      chk_en("br", 1'b1);
      tick();
      #2;
      chk("br2_if_rn", 32'(hz_if.IF_rst_n), 32'd1);
      chk("br2_ex_rn", 32'(hz_if.EX_rst_n), 32'd1);
      chk("br_flush_cnt", 32'(hz_if.flush_count_o), 32'd1);
      tick();
      hz_if.MEM_pc_br = 0;
      #2;
      chk("br_after_cnt", 32'(hz_if.flush_count_o), 32'd1);

      // Flush collides with load-use: flush wins
      tick();
      hz_if.MEM_pc_br = 1; hz_if.EX_ld_en = 1; hz_if.ID_rs2_used = 1;
      #2;
      chk("col_if_en", 32'(hz_if.IF_stall_en), 32'd1);
      chk("col_id_en", 32'(hz_if.ID_stall_en), 32'd1);
      chk("col_id_rn", 32'(hz_if.ID_rst_n), 32'd0);
      tick();
      hz_if.MEM_pc_br = 0; hz_if.EX_ld_en = 0; hz_if.ID_rs2_used = 0;
      #2;
      chk("col_flush_cnt", 32'(hz_if.flush_count_o), 32'd2);
      chk("col_stall_cnt", 32'(hz_if.stall_cycles_o), 32'd1);

      // MUL/DIV with done four cycles after start
      tick();
      hz_if.EX_md_en = 1;
      #2;
      chk("md_start", 32'(hz_if.md_start_o), 32'd1);
      chk_en("md_c0", 1'b0);
      for (int k = 1; k < 4; k++) begin
         tick();
         #2;
         chk("md_wait_start", 32'(hz_if.md_start_o), 32'd0);
         chk_en("md_wait", 1'b0);
      end
      tick();
      hz_if.md_done_i = 1;
      #2;
      chk_en("md_done", 1'b1);
      chk("md_done_start", 32'(hz_if.md_start_o), 32'd0);
      tick();
      hz_if.md_done_i = 0;
      #2;
      chk("md_no_restart", 32'(hz_if.md_start_o), 32'd0);
      chk_en("md_after", 1'b1);
      chk("md_stall_cnt", 32'(hz_if.stall_cycles_o), 32'd5);
      chk("md_tmo_clear", 32'(hz_if.md_timeout_o), 32'd0);

      // Timeout with no done pulse
      tick();
      hz_if.EX_md_en = 0;
      tick();
      hz_if.EX_md_en = 1;
      #2;
      chk("to_start", 32'(hz_if.md_start_o), 32'd1);
      tick();
      hz_if.EX_md_en = 0;
      for (int k = 1; k < 8; k++) begin
         #2;
         chk("to_wait_en", 32'(hz_if.IF_stall_en), 32'd0);
         tick();
      end
      #2;
      chk_en("to_release", 1'b1);
      tick();
      #2;
      chk("to_flag", 32'(hz_if.md_timeout_o), 32'd1);
      chk("to_stall_cnt", 32'(hz_if.stall_cycles_o), 32'd13);
      chk("to_running_en", 32'(hz_if.IF_stall_en), 32'd1);
      tick(); tick();
      chk("to_sticky", 32'(hz_if.md_timeout_o), 32'd1);

      // Reset in the middle of MD_WAIT
      hz_if.EX_md_en = 1;
      tick();
      hz_if.EX_md_en = 0;
      tick();
      #1;
      chk("pre_rst_en", 32'(hz_if.IF_stall_en), 32'd0);
      rst_i = 1'b1;
      #1;
      chk_en("mid_rst", 1'b1);
      chk("mid_rst_stall", 32'(hz_if.stall_cycles_o), 32'd0);
      chk("mid_rst_flush", 32'(hz_if.flush_count_o), 32'd0);
      chk("mid_rst_tmo", 32'(hz_if.md_timeout_o), 32'd0);
      chk("mid_rst_start", 32'(hz_if.md_start_o), 32'd0);
      tick();
      rst_i = 1'b0;
      hz_if.EX_md_en = 1;
      #2;
      chk("post_rst_start", 32'(hz_if.md_start_o), 32'd1);
      tick();
      hz_if.EX_md_en = 0;
      hz_if.md_done_i = 1;
      #2;
      chk_en("post_rst_done", 1'b1);
      tick();
      hz_if.md_done_i = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
